// File: rtl/jk_excite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jk_excite_ctrl
// Brief    : Loads a target value into a JK flip-flop bank.
//            The controller drives J/K, waits for the bank to settle, checks
//            Q against the target, and retries when Q does not match.
// Option   : JK_TOGGLE_DRIVE_EN selects the toggle excitation (J = K = q ^ t).
// Revision : 1.0
// ============================================================================
module jk_excite_ctrl #(
   parameter int WIDTH     = 4,
   parameter int SETTLE    = 1,
   parameter int MAX_RETRY = 3
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             tgt_valid,
   input  logic [WIDTH-1:0] tgt,
   output logic             tgt_ready,
   input  logic [WIDTH-1:0] q_fb,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [3:0]       retries
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DRIVE  = 2'd1,
      S_SETTLE = 2'd2,
      S_CHECK  = 2'd3
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_tgt, w_tgt_nxt;
   logic [WIDTH-1:0] r_j, w_j_nxt;
   logic [WIDTH-1:0] r_k, w_k_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic [3:0]       r_retries, w_retries_nxt;
   logic             r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic [WIDTH-1:0] w_ex_t, w_ex_j, w_ex_k;
   logic             w_match;

   // Excitation target: the live input on accept, the latched copy on retry.
   assign w_ex_t  = (r_state == S_IDLE) ? tgt : r_tgt;
   assign w_match = (q_fb == r_tgt);

`ifdef JK_TOGGLE_DRIVE_EN
   assign w_ex_j = q_fb ^ w_ex_t;
   assign w_ex_k = q_fb ^ w_ex_t;
`else
   assign w_ex_j = ~q_fb & w_ex_t;
   assign w_ex_k = q_fb & ~w_ex_t;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_tgt_nxt     = r_tgt;
      w_j_nxt       = '0;
      w_k_nxt       = '0;
      w_cnt_nxt     = r_cnt;
      w_retries_nxt = r_retries;
      w_done_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (tgt_valid) begin
               w_tgt_nxt     = tgt;
               w_j_nxt       = w_ex_j;
               w_k_nxt       = w_ex_k;
               w_retries_nxt = 4'd0;
               w_state_nxt   = S_DRIVE;
            end
         end
         S_DRIVE: begin
            w_cnt_nxt   = CW'(SETTLE - 1);
            w_state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_CHECK;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         S_CHECK: begin
            if (w_match) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_retries < 4'(MAX_RETRY)) begin
               w_retries_nxt = r_retries + 4'd1;
               w_j_nxt       = w_ex_j;
               w_k_nxt       = w_ex_k;
               w_state_nxt   = S_DRIVE;
            end else begin
               w_done_nxt  = 1'b1;
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_state   <= S_IDLE;
         r_tgt     <= '0;
         r_j       <= '0;
         r_k       <= '0;
         r_cnt     <= '0;
         r_retries <= 4'd0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_tgt     <= w_tgt_nxt;
         r_j       <= w_j_nxt;
         r_k       <= w_k_nxt;
         r_cnt     <= w_cnt_nxt;
         r_retries <= w_retries_nxt;
         r_done    <= w_done_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign tgt_ready = (r_state == S_IDLE) && !clr;
   assign busy      = (r_state != S_IDLE);
   assign J         = r_j;
   assign K         = r_k;
   assign done      = r_done;
   assign err       = r_err;
   assign retries   = r_retries;

endmodule
`default_nettype wire

// File: tb/tb_jk_excite_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jk_excite_ctrl
// Brief    : Bench for jk_excite_ctrl with a JK bank model that supports stuck bits.
//            Also honours JK_TOGGLE_DRIVE_EN.
// Revision : 1.0
// ============================================================================
module tb_jk_excite_ctrl;

   localparam int W  = 4;
   localparam int ST = 1;
   localparam int MR = 3;

   logic         clk = 1'b0;
   logic         clr = 1'b1;
   logic         tgt_valid = 1'b0;
   logic [W-1:0] tgt = '0;
   logic         tgt_ready;
   logic [W-1:0] q_fb;
   logic [W-1:0] J, K;
   logic         busy, done, err;
   logic [3:0]   retries;

   logic [W-1:0] bank_q;
   logic         bank_ld = 1'b0;
   logic [W-1:0] bank_val = '0;
   logic [W-1:0] s0 = '0;
   logic [W-1:0] s1 = '0;

   int vectors = 0;
   int errors  = 0;

   jk_excite_ctrl #(.WIDTH(W), .SETTLE(ST), .MAX_RETRY(MR)) dut (
      .clk(clk), .clr(clr), .tgt_valid(tgt_valid), .tgt(tgt),
      .tgt_ready(tgt_ready), .q_fb(q_fb), .J(J), .K(K),
      .busy(busy), .done(done), .err(err), .retries(retries)
   );

   always #5 clk = ~clk;

   // JK bank with optional stuck-at-0 (s0) and stuck-at-1 (s1) bits.
   always @(posedge clk) begin
      if (bank_ld) bank_q <= (bank_val | s1) & ~s0;
      else         bank_q <= (((J & ~bank_q) | (~K & bank_q)) | s1) & ~s0;
   end
   assign q_fb = bank_q;

   task automatic preset(input logic [W-1:0] v);
      @(negedge clk);
      bank_ld = 1'b1; bank_val = v;
      @(posedge clk); #1;
      bank_ld = 1'b0;
   endtask

   // Full operation: checks drive values, the timing of done, and the final status.
   task automatic run_op(input logic [W-1:0] t, input logic nv, input logic [W-1:0] nt);
      logic [W-1:0] q, q_after, ej, ek;
      int att;
      @(negedge clk);
      tgt = t; tgt_valid = 1'b1;
      q = bank_q;
      vectors++;
      if (tgt_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b expected 1", tgt_ready); end
      @(posedge clk); #1;
      tgt_valid = nv; tgt = nt;
      q_after = (t & ~s0) | s1;
      att = (q_after == t) ? 1 : MR + 1;
      for (int a = 0; a < att; a++) begin
`ifdef JK_TOGGLE_DRIVE_EN
         ej = q ^ t; ek = q ^ t;
`else
         ej = ~q & t; ek = q & ~t;
`endif
         vectors++;
         if (J !== ej || K !== ek || busy !== 1'b1) begin
            errors++;
            $display("FAIL drive%0d: got J=%b K=%b busy=%b expected J=%b K=%b busy=1", a, J, K, busy, ej, ek);
         end
         for (int c = 1; c <= 2 + ST; c++) begin
            @(posedge clk); #1;
            if (!(a == att - 1 && c == 2 + ST)) begin
               vectors++;
               if (done !== 1'b0) begin errors++; $display("FAIL early_done: got %b expected 0", done); end
            end
         end
         q = q_after;
      end
      vectors++;
      if (done !== 1'b1 || err !== (att != 1) || retries !== 4'(att - 1) || busy !== 1'b0 || J !== '0 || K !== '0) begin
         errors++;
         $display("FAIL finish: got done=%b err=%b retries=%0d busy=%b J=%b K=%b expected done=1 err=%b retries=%0d busy=0 J=K=0",
                  done, err, retries, busy, J, K, att != 1, att - 1);
      end
      if (!nv) begin
         @(posedge clk); #1;
         vectors++;
         if (done !== 1'b0 || err !== 1'b0 || retries !== 4'(att - 1)) begin
            errors++;
            $display("FAIL pulse_len: got done=%b err=%b retries=%0d expected 0 0 %0d", done, err, retries, att - 1);
         end
      end
   endtask

   task automatic test_reset;
      clr = 1'b1; tgt_valid = 1'b1; tgt = 4'b1111;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if (tgt_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", tgt_ready); end
         @(posedge clk); #1;
      end
      vectors++;
      if (J !== '0 || K !== '0 || done !== 1'b0 || err !== 1'b0 || busy !== 1'b0 || retries !== 4'd0) begin
         errors++;
         $display("FAIL reset_state: got J=%b K=%b done=%b err=%b busy=%b retries=%0d expected all 0", J, K, done, err, busy, retries);
      end
      tgt_valid = 1'b0;
      @(negedge clk);
      clr = 1'b0;
      #1;
      vectors++;
      if (tgt_ready !== 1'b1) begin errors++; $display("FAIL reset_release: got ready=%b expected 1", tgt_ready); end
   endtask

   task automatic test_basic;
      s0 = '0; s1 = '0;
      preset(4'b0000); run_op(4'b1010, 1'b0, '0);
      vectors++;
      if (bank_q !== 4'b1010) begin errors++; $display("FAIL basic_q: got %b expected 1010", bank_q); end
      preset(4'b1111); run_op(4'b1111, 1'b0, '0);
      preset(4'b0110); run_op(4'b0011, 1'b0, '0);
   endtask

   task automatic test_stuck;
      s0 = 4'b0001; s1 = '0;
      preset(4'b0000); run_op(4'b0001, 1'b0, '0);
      s0 = '0;
   endtask

   task automatic test_clr_settle;
      preset(4'b0000);
      @(negedge clk);
      tgt = 4'b1010; tgt_valid = 1'b1;
      @(posedge clk); #1;
      tgt_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || J !== '0 || K !== '0 || done !== 1'b0 || err !== 1'b0 || retries !== 4'd0 || tgt_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_mid: got busy=%b J=%b K=%b done=%b err=%b retries=%0d ready=%b expected 0s",
                  busy, J, K, done, err, retries, tgt_ready);
      end
      @(negedge clk);
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         vectors++;
         if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL clr_no_pulse: got done=%b err=%b busy=%b expected 0 0 0", done, err, busy);
         end
      end
      run_op(4'b0101, 1'b0, '0);
   endtask

   task automatic test_back_to_back;
      s0 = '0; s1 = '0;
      preset(4'b1100);
      run_op(4'b0011, 1'b1, 4'b1001);
      run_op(4'b1001, 1'b1, 4'b0110);
      run_op(4'b0110, 1'b0, '0);
   endtask

   task automatic test_random;
      logic [W-1:0] m;
      for (int i = 0; i < 20; i++) begin
         m = W'(1 << $urandom_range(0, W - 1));
         s0 = '0; s1 = '0;
         case ($urandom_range(0, 3))
            0: s0 = m;
            1: s1 = m;
            default: ;
         endcase
         preset(W'($urandom));
         run_op(W'($urandom), 1'b0, '0);
      end
      s0 = '0; s1 = '0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stuck();
      test_clr_settle();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/jk_excite_ctrl.md
# jk_excite_ctrl

Drive-side controller for a bank of JK flip-flops. It accepts a target register value over a valid/ready handshake. It computes the J/K excitation from the bank's fed-back Q and target, drives it for one clock, waits for the bank to settle, then checks Q against the target and retries on mismatch. It sits in front of any JK register bank in the sequential library and turns "load this value" into per-bit J/K commands.

## Interface
- WIDTH, 4, number of JK flip-flops driven
- SETTLE, 1, cycles held in SETTLE before checking Q (≥1)
- MAX_RETRY, 3, extra drive attempts after a failed check (0–15)

- clk  in  1  clock; the JK bank shares it
- clr  in  1  reset, synchronous, active-high
- tgt_valid  in  1  target offered
- tgt  in  WIDTH  target Q value
- tgt_ready  out  1  controller can accept; combinational, equals (state==IDLE) && !clr
- q_fb  in  WIDTH  Q outputs of the JK bank
- J  out  WIDTH  J drive, registered
- K  out  WIDTH  K drive, registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, operation finished
- err  out  1  one-cycle pulse with done, Q never matched target
- retries  out  4  retries used by last/current operation

## Operation
- Excitation, per bit (default): J = ~q & t, K = q & ~t; bits already correct get J=K=0 (hold).
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE: on tgt_valid && tgt_ready latch tgt into tgt_reg, J/K <= excite(q_fb, tgt), retries <= 0, go DRIVE; otherwise J=K=0.
- DRIVE: one cycle with J/K asserted; next edge J=K <= 0, settle counter <= SETTLE-1, go SETTLE.
- SETTLE: J=K=0; decrement counter; at counter 0 go CHECK.
- CHECK: compare q_fb to tgt_reg at the closing edge:
  - match: done <= 1, go IDLE.
  - mismatch, retries < MAX_RETRY: retries++, J/K <= excite(q_fb, tgt_reg), go DRIVE.
  - mismatch, retries == MAX_RETRY: done <= 1, err <= 1, go IDLE.
- done/err are registered and held for exactly one cycle. retries holds its value until the next accept.
- Target equal to current Q: J=K=0 drive, full sequence runs, done without err.
- tgt_valid while busy: ignored. The source holds tgt until ready.
- MAX_RETRY=0: a single attempt, then done or done+err.

## Timing
- Reset: clr high at an edge forces state IDLE, J=K=0, done=err=0, retries=0, tgt_reg=0. tgt_ready is low while clr is high. clr overrides all other inputs.
- clr mid-operation: the in-flight target is dropped with no done/err pulse. The controller is ready the cycle after clr deasserts.
- Accept at edge E: J/K valid after E; the bank captures at E+1; CHECK closes at edge E+2+SETTLE; done is high for the cycle after that edge.
- Each retry adds 2+SETTLE cycles (DRIVE, SETTLE×SETTLE, CHECK).
- tgt_ready rises in the same cycle done is high. Back-to-back accepts are possible at edge E+3+SETTLE.
- q_fb is sampled only at the CHECK closing edge and at accept/retry edges.

## Configuration
- JK_TOGGLE_DRIVE_EN defined: excitation uses the toggle form J = K = q ^ t, so wrong bits toggle and correct bits hold.
- JK_TOGGLE_DRIVE_EN undefined: the set/reset form from Operation is used.
- FSM, timing and handshake are identical in both builds.

## Test plan
(WIDTH=4, SETTLE=1, MAX_RETRY=3, behavioural JK bank on the same clk)
- Reset: clr high 2 cycles mid-stream -> J=K=0000, done=err=busy=0, retries=0, tgt_ready=0 during clr and 1 the cycle after.
- q=0000, tgt=1010 accepted at edge E -> J=1010, K=0000 for one cycle; q=1010 after E+1; done=1, err=0 after E+3; retries=0.
- q=1111, tgt=1111 -> J=K=0000; done after E+3, err=0.
- Bank bit0 stuck at 0, tgt=0001 -> J=0001 on each of 4 drives; done=err=1 after E+12; retries=3.
- clr asserted during SETTLE -> no done/err pulse; IDLE, J=K=0 next cycle; a new target is accepted normally.
- q=0110, tgt=0011: without JK_TOGGLE_DRIVE_EN -> J=0001, K=0100; with it -> J=K=0101. Both end done, err=0.
